// File: rtl/div_seq_ctrl.sv
// Multi-cycle radix-2 restoring divider for the EXE stage: signed/unsigned
// quotient and remainder with a valid/ready request and a held result.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [3:0]       div_op,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    input  logic             div_valid,
    output logic             div_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude in WIDTH-bit unsigned, so the most negative value maps to itself.
    function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg_f(v) : v;
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   dvd_r;
    logic [WIDTH-1:0]   dsr_r;
    logic [WIDTH-1:0]   src1_r;
    logic               want_rem_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               dz_r;
    logic               div_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic [WIDTH-1:0]   out_result_r;

    logic               op_legal_s;
    logic               accept_s;
    logic               signed_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic [WIDTH-1:0]   result_s;

    assign div_ready  = div_ready_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign out_result = out_result_r;

    // Request decode: legal one-hot op and the accept condition.
    always_comb begin
        op_legal_s = (div_op != 4'b0000) && ((div_op & (div_op - 4'b0001)) == 4'b0000);
        accept_s   = div_valid && div_ready_r && !flush && op_legal_s;
        signed_s   = div_op[1] | div_op[3];
    end

    // Iteration datapath (33-bit trial subtract) and final sign/zero fix-up.
    always_comb begin
        rem_sh_s = {rem_r, dvd_r[WIDTH-1]};
        trial_s  = rem_sh_s - {1'b0, dsr_r};
        if (dz_r) begin
            quo_fix_s = {WIDTH{1'b1}};
            rem_fix_s = src1_r;
        end else begin
            quo_fix_s = neg_q_r ? neg_f(dvd_r) : dvd_r;
            rem_fix_s = neg_r_r ? neg_f(rem_r) : rem_r;
        end
        result_s = want_rem_r ? rem_fix_s : quo_fix_s;
    end

    // Sequencer FSM with registered handshake outputs; reset beats flush beats all else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            rem_r        <= {WIDTH{1'b0}};
            dvd_r        <= {WIDTH{1'b0}};
            dsr_r        <= {WIDTH{1'b0}};
            src1_r       <= {WIDTH{1'b0}};
            want_rem_r   <= 1'b0;
            neg_q_r      <= 1'b0;
            neg_r_r      <= 1'b0;
            dz_r         <= 1'b0;
            div_ready_r  <= 1'b1;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            out_result_r <= {WIDTH{1'b0}};
        end else if (flush) begin
            state_r     <= IDLE;
            div_ready_r <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        want_rem_r  <= div_op[0] | div_op[1];
                        neg_q_r     <= signed_s & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
                        neg_r_r     <= signed_s & div_src1[WIDTH-1];
                        dz_r        <= (div_src2 == {WIDTH{1'b0}});
                        src1_r      <= div_src1;
                        dvd_r       <= signed_s ? abs_f(div_src1) : div_src1;
                        dsr_r       <= signed_s ? abs_f(div_src2) : div_src2;
                        rem_r       <= {WIDTH{1'b0}};
                        cnt_r       <= {CNT_W{1'b0}};
                        div_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= CALC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    if (trial_s[WIDTH]) begin
                        rem_r <= rem_sh_s[WIDTH-1:0];
                        dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_r <= trial_s[WIDTH-1:0];
                        dvd_r <= {dvd_r[WIDTH-2:0], 1'b1};
                    end
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    out_result_r <= result_s;
                    out_valid_r  <= 1'b1;
                    state_r      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        div_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    div_ready_r <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule
